// File: rtl/cache_tag_plru.sv
// cache_tag_plru: set-associative tag store with per-set tree pseudo-LRU,
// victim selection and a one-set-per-cycle invalidate-all sweep.
// Lookups are two-stage: stage 1 reads the set (with same-cycle fill and
// touch bypass), stage 2 compares and selects the victim from held registers.
module cache_tag_plru #(
  parameter int NUM_WAYS     = 4,
  parameter int NUM_SETS     = 16,
  parameter int TAG_WIDTH    = 22,
  parameter int NUM_WAYS_LOG = $clog2(NUM_WAYS),
  parameter int NUM_SETS_LOG = $clog2(NUM_SETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    access_en,
  input  logic [NUM_SETS_LOG-1:0] access_set_idx,
  input  logic [TAG_WIDTH-1:0]    access_tag,
  output logic                    access_rsp_valid,
  output logic [NUM_WAYS-1:0]     access_hit_oh,
  output logic                    access_hit,
  output logic [NUM_WAYS_LOG-1:0] access_hit_way_idx,
  output logic [NUM_WAYS_LOG-1:0] access_victim_way_idx,
  output logic                    access_victim_valid,
  output logic [TAG_WIDTH-1:0]    access_victim_tag,
  input  logic                    update_en,
  input  logic [NUM_WAYS_LOG-1:0] update_way_idx,
  input  logic [NUM_SETS_LOG-1:0] update_set_idx,
  input  logic [TAG_WIDTH-1:0]    update_tag,
  input  logic                    update_valid,
  input  logic                    flush_en,
  output logic                    flush_busy,
  output logic                    flush_done
);

  localparam int PLRU_W = NUM_WAYS - 1;

  // Heap-ordered tree: node 0 is the root, children of n are 2n+1 and 2n+2.
  // A node bit of 0 points at its lower half.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [NUM_WAYS_LOG-1:0] way);
    logic [PLRU_W-1:0] res;
    int node;
    res  = bits;
    node = 0;
    for (int lvl = NUM_WAYS_LOG - 1; lvl >= 0; lvl--) begin
      res[node] = ~way[lvl];
      node      = 2 * node + 1 + int'(way[lvl]);
    end
    return res;
  endfunction

  function automatic logic [NUM_WAYS_LOG-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [NUM_WAYS_LOG-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int lvl = NUM_WAYS_LOG - 1; lvl >= 0; lvl--) begin
      way[lvl] = bits[node];
      node     = 2 * node + 1 + int'(bits[node]);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS_LOG-1:0] first_invalid(input logic [NUM_WAYS-1:0] v);
    logic [NUM_WAYS_LOG-1:0] idx;
    idx = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!v[w]) idx = NUM_WAYS_LOG'(w);
    end
    return idx;
  endfunction

  function automatic logic [NUM_WAYS_LOG-1:0] oh_encode(input logic [NUM_WAYS-1:0] oh);
    logic [NUM_WAYS_LOG-1:0] idx;
    idx = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (oh[w]) idx = idx | NUM_WAYS_LOG'(w);
    end
    return idx;
  endfunction

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SETS_LOG-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                    sweep_active;

  logic [TAG_WIDTH-1:0]    tag_mem [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [PLRU_W-1:0]       plru_q  [NUM_SETS];

  logic                    upd_apply;
  logic                    upd_touch;
  logic [PLRU_W-1:0]       plru_upd_new;
  logic                    hit_touch;
  logic [PLRU_W-1:0]       plru_hit_new;

  logic [TAG_WIDTH-1:0]    tag_rd [NUM_WAYS];
  logic [NUM_WAYS-1:0]     valid_rd;
  logic [PLRU_W-1:0]       plru_rd;

  logic                    vld_p1;
  logic [NUM_SETS_LOG-1:0] set_p1;
  logic [TAG_WIDTH-1:0]    acc_tag_p1;
  logic [TAG_WIDTH-1:0]    way_tag_p1 [NUM_WAYS];
  logic [NUM_WAYS-1:0]     valid_p1;
  logic [PLRU_W-1:0]       plru_p1;
  logic                    sweep_p1;

  logic [NUM_WAYS-1:0]     hit_raw;
  logic [NUM_WAYS_LOG-1:0] victim_way;

  assign sweep_active = (state_q == SWEEP);
  assign flush_busy   = sweep_active;
  assign flush_done   = sweep_active && (sweep_cnt_q == NUM_SETS_LOG'(NUM_SETS - 1));

  // Updates are dropped while the sweep owns the valid/PLRU state.
  assign upd_apply    = update_en && !sweep_active;
  assign upd_touch    = upd_apply && update_valid;
  assign plru_upd_new = plru_touch(plru_q[update_set_idx], update_way_idx);

  // A stage-2 hit touches its way unless a fill touches the same set this cycle.
  assign hit_touch    = vld_p1 && access_hit &&
                        !(upd_touch && (update_set_idx == set_p1));
  assign plru_hit_new = plru_touch(plru_q[set_p1], access_hit_way_idx);

  // Flush sequencer next-state: IDLE waits for flush_en, SWEEP walks every set once.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_en) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      SWEEP: begin
        if (sweep_cnt_q == NUM_SETS_LOG'(NUM_SETS - 1)) begin
          state_d     = IDLE;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        sweep_cnt_d = '0;
      end
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Tag SRAM write port; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (upd_apply) tag_mem[update_way_idx][update_set_idx] <= update_tag;
  end

  // Valid and PLRU state: sweep clear beats fills; fill touch beats hit touch in one set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        if (sweep_active && (sweep_cnt_q == NUM_SETS_LOG'(s))) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end else begin
          if (upd_apply && (update_set_idx == NUM_SETS_LOG'(s)))
            valid_q[s][update_way_idx] <= update_valid;
          if (upd_touch && (update_set_idx == NUM_SETS_LOG'(s)))
            plru_q[s] <= plru_upd_new;
          else if (hit_touch && (set_p1 == NUM_SETS_LOG'(s)))
            plru_q[s] <= plru_hit_new;
        end
      end
    end
  end

  // Stage-1 read of the addressed set, merged with this cycle's fill, touches and sweep clear.
  always_comb begin
    valid_rd = valid_q[access_set_idx];
    plru_rd  = plru_q[access_set_idx];
    for (int w = 0; w < NUM_WAYS; w++) tag_rd[w] = tag_mem[w][access_set_idx];
    if (upd_apply && (update_set_idx == access_set_idx)) begin
      valid_rd[update_way_idx] = update_valid;
      tag_rd[update_way_idx]   = update_tag;
    end
    if (upd_touch && (update_set_idx == access_set_idx))
      plru_rd = plru_upd_new;
    else if (hit_touch && (set_p1 == access_set_idx))
      plru_rd = plru_hit_new;
    if (sweep_active && (sweep_cnt_q == access_set_idx)) begin
      valid_rd = '0;
      plru_rd  = '0;
    end
  end

  // ---- stage 1 -> stage 2 boundary: results hold while no lookup is issued ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      set_p1     <= '0;
      acc_tag_p1 <= '0;
      valid_p1   <= '0;
      plru_p1    <= '0;
      sweep_p1   <= 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) way_tag_p1[w] <= '0;
    end else begin
      vld_p1 <= access_en;
      if (access_en) begin
        set_p1     <= access_set_idx;
        acc_tag_p1 <= access_tag;
        valid_p1   <= valid_rd;
        plru_p1    <= plru_rd;
        sweep_p1   <= sweep_active;
        for (int w = 0; w < NUM_WAYS; w++) way_tag_p1[w] <= tag_rd[w];
      end
    end
  end

  // Stage-2 compare and victim choice; lookups issued during a sweep never report valid lines.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++)
      hit_raw[w] = valid_p1[w] && (way_tag_p1[w] == acc_tag_p1);
    access_hit_oh      = sweep_p1 ? '0 : hit_raw;
    access_hit         = |access_hit_oh;
    access_hit_way_idx = oh_encode(access_hit_oh);
    if (&valid_p1) begin
      victim_way          = plru_victim(plru_p1);
      access_victim_valid = !sweep_p1;
    end else begin
      victim_way          = first_invalid(valid_p1);
      access_victim_valid = 1'b0;
    end
    access_victim_way_idx = victim_way;
    access_victim_tag     = way_tag_p1[victim_way];
    access_rsp_valid      = vld_p1;
  end

endmodule

// File: tb/tb_cache_tag_plru.sv
// Directed bench for cache_tag_plru: expected lookup results are queued when
// a lookup is driven and compared when the response appears one cycle later.
module tb_cache_tag_plru;

  logic        clk = 1'b0;
  logic        rst;
  logic        access_en;
  logic [3:0]  access_set_idx;
  logic [21:0] access_tag;
  logic        access_rsp_valid;
  logic [3:0]  access_hit_oh;
  logic        access_hit;
  logic [1:0]  access_hit_way_idx;
  logic [1:0]  access_victim_way_idx;
  logic        access_victim_valid;
  logic [21:0] access_victim_tag;
  logic        update_en;
  logic [1:0]  update_way_idx;
  logic [3:0]  update_set_idx;
  logic [21:0] update_tag;
  logic        update_valid;
  logic        flush_en;
  logic        flush_busy;
  logic        flush_done;

  typedef struct {
    logic [3:0]  oh;
    logic [1:0]  way;
    logic [1:0]  vway;
    logic        vvalid;
    logic [21:0] vtag;
    logic        chk_tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cache_tag_plru dut (
    .clk                   (clk),
    .rst                   (rst),
    .access_en             (access_en),
    .access_set_idx        (access_set_idx),
    .access_tag            (access_tag),
    .access_rsp_valid      (access_rsp_valid),
    .access_hit_oh         (access_hit_oh),
    .access_hit            (access_hit),
    .access_hit_way_idx    (access_hit_way_idx),
    .access_victim_way_idx (access_victim_way_idx),
    .access_victim_valid   (access_victim_valid),
    .access_victim_tag     (access_victim_tag),
    .update_en             (update_en),
    .update_way_idx        (update_way_idx),
    .update_set_idx        (update_set_idx),
    .update_tag            (update_tag),
    .update_valid          (update_valid),
    .flush_en              (flush_en),
    .flush_busy            (flush_busy),
    .flush_done            (flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic req_lookup(input logic [3:0] set, input logic [21:0] tag,
                            input logic [3:0] oh, input logic [1:0] way,
                            input logic [1:0] vway, input logic vvalid,
                            input logic [21:0] vtag, input logic chk_tag);
    exp_t e;
    access_en      = 1'b1;
    access_set_idx = set;
    access_tag     = tag;
    e.oh = oh; e.way = way; e.vway = vway; e.vvalid = vvalid; e.vtag = vtag; e.chk_tag = chk_tag;
    sb.push_back(e);
  endtask

  task automatic req_update(input logic [3:0] set, input logic [1:0] way,
                            input logic [21:0] tag, input logic valid);
    update_en      = 1'b1;
    update_set_idx = set;
    update_way_idx = way;
    update_tag     = tag;
    update_valid   = valid;
  endtask

  // Advance one clock, check any response against the scoreboard, then clear requests.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(access_rsp_valid), 32'(sb.size() != 0));
    if (access_rsp_valid && (sb.size() != 0)) begin
      e = sb.pop_front();
      chk("hit_oh", 32'(access_hit_oh), 32'(e.oh));
      chk("hit", 32'(access_hit), 32'(|e.oh));
      chk("hit_way", 32'(access_hit_way_idx), 32'(e.way));
      chk("victim_way", 32'(access_victim_way_idx), 32'(e.vway));
      chk("victim_valid", 32'(access_victim_valid), 32'(e.vvalid));
      if (e.chk_tag) chk("victim_tag", 32'(access_victim_tag), 32'(e.vtag));
    end
    access_en = 1'b0;
    update_en = 1'b0;
    flush_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    access_en = 1'b0; access_set_idx = '0; access_tag = '0;
    update_en = 1'b0; update_way_idx = '0; update_set_idx = '0;
    update_tag = '0; update_valid = 1'b0; flush_en = 1'b0;

    // Outputs stay zero during reset even with requests present.
    repeat (2) @(posedge clk);
    #1;
    access_en = 1'b1; access_set_idx = 4'd3; access_tag = 22'h1234;
    flush_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(access_rsp_valid), 0);
    chk("rst_hit_oh", 32'(access_hit_oh), 0);
    chk("rst_hit", 32'(access_hit), 0);
    chk("rst_hit_way", 32'(access_hit_way_idx), 0);
    chk("rst_victim_way", 32'(access_victim_way_idx), 0);
    chk("rst_victim_valid", 32'(access_victim_valid), 0);
    chk("rst_victim_tag", 32'(access_victim_tag), 0);
    chk("rst_flush_busy", 32'(flush_busy), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    access_en = 1'b0; flush_en = 1'b0;
    rst = 1'b0;

    // Cold lookup misses with way 0 as an invalid victim.
    req_lookup(4'd3, 22'h1234, 4'b0000, 2'd0, 2'd0, 1'b0, 22'h0, 1'b0);
    tick();

    // Fill set 5, then back-to-back hits steer the PLRU to way 3.
    for (int w = 0; w < 4; w++) begin
      req_update(4'd5, 2'(w), 22'(32'hA0 + w), 1'b1);
      tick();
    end
    req_lookup(4'd5, 22'hA0, 4'b0001, 2'd0, 2'd0, 1'b1, 22'hA0, 1'b1);
    tick();
    req_lookup(4'd5, 22'hA2, 4'b0100, 2'd2, 2'd2, 1'b1, 22'hA2, 1'b1);
    tick();
    req_lookup(4'd5, 22'hA1, 4'b0010, 2'd1, 2'd1, 1'b1, 22'hA1, 1'b1);
    tick();
    req_lookup(4'd5, 22'hFF, 4'b0000, 2'd0, 2'd3, 1'b1, 22'hA3, 1'b1);
    tick();

    // Same-cycle fill is bypassed into the lookup.
    req_update(4'd7, 2'd2, 22'h55, 1'b1);
    req_lookup(4'd7, 22'h55, 4'b0100, 2'd2, 2'd0, 1'b0, 22'h0, 1'b0);
    tick();

    // Invalidate set 5 way 1, miss on it, refill it; tree still points at way 3.
    req_update(4'd5, 2'd1, 22'h0, 1'b0);
    tick();
    req_lookup(4'd5, 22'hA1, 4'b0000, 2'd0, 2'd1, 1'b0, 22'h0, 1'b0);
    tick();
    req_update(4'd5, 2'd1, 22'hA1, 1'b1);
    tick();
    req_lookup(4'd5, 22'hA1, 4'b0010, 2'd1, 2'd3, 1'b1, 22'hA3, 1'b1);
    tick();

    // Valid line in every set, then a full sweep.
    for (int s = 0; s < 16; s++) begin
      req_update(4'(s), 2'd0, 22'(32'h100 + s), 1'b1);
      tick();
    end
    req_lookup(4'd9, 22'h109, 4'b0001, 2'd0, 2'd1, 1'b0, 22'h0, 1'b0);
    tick();
    flush_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("sweep_busy", 32'(flush_busy), 1);
      chk("sweep_done", 32'(flush_done), 32'(i == 16));
      if (i == 1) req_lookup(4'd9, 22'h109, 4'b0000, 2'd0, 2'd1, 1'b0, 22'h0, 1'b0);
      if (i == 3) req_update(4'd0, 2'd1, 22'h77, 1'b1);
      if (i == 5) flush_en = 1'b1;
    end
    tick();
    chk("post_sweep_busy", 32'(flush_busy), 0);
    chk("post_sweep_done", 32'(flush_done), 0);
    for (int s = 0; s < 16; s++) begin
      req_lookup(4'(s), 22'(32'h100 + s), 4'b0000, 2'd0, 2'd0, 1'b0, 22'h0, 1'b0);
      tick();
    end
    req_lookup(4'd0, 22'h77, 4'b0000, 2'd0, 2'd0, 1'b0, 22'h0, 1'b0);
    tick();

    // Reset in sweep cycle 6 aborts at once; a later flush runs a full sweep.
    req_update(4'd12, 2'd0, 22'h44, 1'b1);
    tick();
    flush_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("abort_busy", 32'(flush_busy), 1);
    end
    rst = 1'b1;
    #1;
    chk("abort_rst_busy", 32'(flush_busy), 0);
    chk("abort_rst_done", 32'(flush_done), 0);
    tick();
    tick();
    rst = 1'b0;
    req_lookup(4'd12, 22'h44, 4'b0000, 2'd0, 2'd0, 1'b0, 22'h0, 1'b0);
    tick();
    flush_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("resweep_busy", 32'(flush_busy), 1);
      chk("resweep_done", 32'(flush_done), 32'(i == 16));
    end
    tick();
    chk("resweep_end_busy", 32'(flush_busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_tag_plru.md
# cache_tag_plru

Set-associative tag array with per-set tree pseudo-LRU replacement, victim selection and a sequenced flush. It serves as the next-generation tag store for the L1/L2 cache pipelines. A lookup issued in cycle N returns hit one-hot, hit way, victim way, victim tag and victim valid in cycle N+1. Fills are bypassed into same-cycle lookups. An invalidate-all sweep clears one set per cycle, so the valid and LRU state remain mappable to SRAM.

## Interface
- NUM_WAYS, 4, associativity; power of two, at least 2
- NUM_SETS, 16, sets; power of two, at least 2
- TAG_WIDTH, 22, tag bits
- NUM_WAYS_LOG, $clog2(NUM_WAYS), derived
- NUM_SETS_LOG, $clog2(NUM_SETS), derived
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- access_en  in  1  lookup request
- access_set_idx  in  NUM_SETS_LOG  lookup set
- access_tag  in  TAG_WIDTH  lookup tag
- access_rsp_valid  out  1  lookup result valid; equals access_en delayed one cycle
- access_hit_oh  out  NUM_WAYS  one-hot matching way
- access_hit  out  1  OR of access_hit_oh
- access_hit_way_idx  out  NUM_WAYS_LOG  encoded hit way; 0 on miss
- access_victim_way_idx  out  NUM_WAYS_LOG  way to fill on miss
- access_victim_valid  out  1  victim way currently holds a valid line
- access_victim_tag  out  TAG_WIDTH  tag of the victim way; used for writeback
- update_en  in  1  tag write
- update_way_idx  in  NUM_WAYS_LOG  way to write
- update_set_idx  in  NUM_SETS_LOG  set to write
- update_tag  in  TAG_WIDTH  tag value
- update_valid  in  1  new valid bit; 0 invalidates the line
- flush_en  in  1  start invalidate-all; single-cycle pulse
- flush_busy  out  1  sweep in progress
- flush_done  out  1  high in the last sweep cycle

## Operation
- Storage per way: tag SRAM with NUM_SETS entries, read-before-write. Valid bits: NUM_WAYS x NUM_SETS. PLRU tree: NUM_WAYS-1 bits per set.
- Lookup stage 1 (cycle N): read all way tags and the set's valid bits and PLRU bits. Register access_set_idx and access_tag.
- Lookup stage 2 (cycle N+1), way w hits when valid[w] is set and tag[w] equals access_tag.
- Bypass: an update_en in cycle N whose update_set_idx equals access_set_idx is reflected in the N+1 result for that way (tag and valid both). An update_en in cycle N+1 does not affect the N+1 result.
- Victim selection:
  - If any way in the set is invalid, the victim is the lowest-index invalid way and access_victim_valid=0.
  - Otherwise the victim is the way the PLRU tree points to and access_victim_valid=1.
- PLRU tree: bit = 0 points to the lower half. A touch sets every node on the path to point away from the touched way.
- Touch events:
  - A stage-2 hit touches the hit way.
  - update_en with update_valid=1 touches update_way_idx.
  - An invalidating update (update_valid=0) does not change the PLRU bits.
  - Same cycle, same set: the update touch wins and the hit touch is dropped.
  - Same cycle, different sets: both touches apply.
- Flush FSM, states IDLE and SWEEP:
  - IDLE to SWEEP on flush_en. The sweep counter starts at 0.
  - In SWEEP, each cycle clears all valid bits and PLRU bits of set[counter], then increments the counter.
  - SWEEP to IDLE after set NUM_SETS-1 is cleared.
  - flush_en while in SWEEP is ignored.
- During SWEEP:
  - Lookups complete normally but access_hit_oh is forced to 0 and access_victim_valid to 0.
  - update_en is dropped. The requester must hold off while flush_busy is high.
- Reset: all valid and PLRU bits cleared, FSM in IDLE, counter 0, and every output 0. Tag SRAM contents are not reset; they are don't-care because the valid bits are 0.
- Reset asserted mid-sweep aborts the sweep. flush_busy and flush_done drop immediately.

## Timing
- Lookup latency is 1 cycle, fully pipelined, one lookup per cycle.
- Result outputs are registered stage-2 values. They hold their last value when access_rsp_valid=0.
- An update in cycle N is visible to lookups issued in cycle N (via bypass) and in every later cycle.
- flush_en in cycle N:
  - flush_busy is high for cycles N+1 through N+NUM_SETS.
  - Set k is cleared at the end of cycle N+1+k.
  - flush_done is high in cycle N+NUM_SETS only.
  - A flush_en arriving in cycle N+NUM_SETS+1 starts a new sweep.
- flush_en in the same cycle as update_en: the update is applied, then the sweep starts next cycle.

## Test plan
- Reset, then look up set 3 with tag 0x1234 -> access_hit=0, victim way 0, access_victim_valid=0. All outputs were 0 during reset.
- Fill set 5 ways 0-3 with tags 0xA0-0xA3, then hit 0xA0, 0xA2, 0xA1 -> hit_way_idx 0, 2, 1. Next lookup victim is way 3 with access_victim_valid=1 and access_victim_tag=0xA3.
- update_en (set 7, way 2, tag 0x55, valid 1) and access (set 7, tag 0x55) in the same cycle -> next cycle access_hit_oh=4'b0100.
- Invalidate set 5 way 1 -> a lookup of 0xA1 misses, victim way 1, access_victim_valid=0, PLRU bits unchanged.
- With valid lines in every set, pulse flush_en -> flush_busy for 16 cycles and flush_done in the 16th. Lookups during the sweep miss. An update during the sweep is dropped. All sets miss afterwards.
- Assert rst at sweep cycle 6 -> flush_busy=0 immediately. After release, all sets are invalid and a new flush_en starts a full 16-cycle sweep.
